// File: rtl/arith_cast_pkg.sv
// Shared helpers for the arith cast units: width helpers and the
// sign-extend/truncate cast used by the shared index-cast datapath.
package arith_cast_pkg;

  localparam int CAST_MAXW = 256;

  typedef logic [CAST_MAXW-1:0] cast_word_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int RR_DEF_REQ = 4;

  typedef logic [clog2_min1(RR_DEF_REQ)-1:0] rr_ptr_t;

  // Sign-extends the low in_w bits of d across the full word;
  // callers keep the low OUT bits, which truncates when OUT <= IN.
  function automatic cast_word_t cast_sext_trunc(
    input cast_word_t d,
    input int         in_w
  );
    cast_word_t hi_mask;
    cast_word_t one;
    logic       sgn;
    one     = cast_word_t'(1);
    hi_mask = ~cast_word_t'(0) << in_w;
    sgn     = |(d & (one << (in_w - 1)));
    return sgn ? (d | hi_mask) : (d & ~hi_mask);
  endfunction

endpackage

// File: rtl/arith_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr,
// wrapping modulo NUM_REQ. Grant is one-hot or zero.
module arith_rr_arbiter
  import arith_cast_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int W       = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [W-1:0]       ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [W-1:0]       grant_idx
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [W-1:0]         off;
  logic [W:0]           sum;
  logic [W:0]           idx;
  logic [W:0]           nreq;
  logic                 found;

  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[NUM_REQ-1:0];
    found = |req;
    nreq  = (W+1)'(NUM_REQ);
    off   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = W'(i);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    idx = (sum >= nreq) ? (sum - nreq) : sum;
    grant_idx = found ? idx[W-1:0] : '0;
    grant = found ? (NUM_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/arith_index_cast_arb.sv
// Round-robin shared index-cast unit with a one-entry registered
// result stage; the winning requester id travels as result_tag.
module arith_index_cast_arb
  import arith_cast_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int IN_WIDTH  = 64,
  parameter  int OUT_WIDTH = 32,
  localparam int TAG_WIDTH = clog2_min1(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*IN_WIDTH-1:0]   req_data,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic [OUT_WIDTH-1:0]          result_data,
  output logic [TAG_WIDTH-1:0]          result_tag
);

  logic [TAG_WIDTH-1:0] rr_ptr;
  logic [NUM_REQ-1:0]   grant;
  logic [TAG_WIDTH-1:0] grant_idx;
  logic [IN_WIDTH-1:0]  ops [NUM_REQ];
  logic [IN_WIDTH-1:0]  sel;
  logic [OUT_WIDTH-1:0] cast_val;
  logic [TAG_WIDTH-1:0] ptr_next;
  logic                 can_accept;
  logic                 accept;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ops
    assign ops[g] = req_data[g*IN_WIDTH +: IN_WIDTH];
  end

  arith_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    can_accept = !result_valid | result_ready;
    accept     = rst_n & can_accept & (|grant);
    req_ready  = grant & {NUM_REQ{rst_n & can_accept}};
    sel        = ops[grant_idx];
    cast_val   = OUT_WIDTH'(cast_sext_trunc(cast_word_t'(sel), IN_WIDTH));
    if (grant_idx == TAG_WIDTH'(NUM_REQ - 1)) ptr_next = '0;
    else ptr_next = grant_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_valid <= 1'b0;
      result_data  <= '0;
      result_tag   <= '0;
      rr_ptr       <= '0;
    end else if (accept) begin
      result_valid <= 1'b1;
      result_data  <= cast_val;
      result_tag   <= grant_idx;
      rr_ptr       <= ptr_next;
    end else if (result_valid && result_ready) begin
      result_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arith_index_cast_arb.sv
// Directed table-driven bench for the shared index-cast arbiter,
// with a truncating 64->32 instance and an extending 16->32 instance.
module tb_arith_index_cast_arb;

  logic         clk;
  logic         rst_n;

  logic [3:0]   a_valid;
  logic [3:0]   a_ready;
  logic [255:0] a_data;
  logic         a_res_valid;
  logic         a_res_ready;
  logic [31:0]  a_res_data;
  logic [1:0]   a_res_tag;

  logic [3:0]   b_valid;
  logic [3:0]   b_ready;
  logic [63:0]  b_data;
  logic         b_res_valid;
  logic         b_res_ready;
  logic [31:0]  b_res_data;
  logic [1:0]   b_res_tag;

  int errors;
  int checks;

  arith_index_cast_arb #(
    .NUM_REQ   (4),
    .IN_WIDTH  (64),
    .OUT_WIDTH (32)
  ) dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (a_valid),
    .req_ready    (a_ready),
    .req_data     (a_data),
    .result_valid (a_res_valid),
    .result_ready (a_res_ready),
    .result_data  (a_res_data),
    .result_tag   (a_res_tag)
  );

  arith_index_cast_arb #(
    .NUM_REQ   (4),
    .IN_WIDTH  (16),
    .OUT_WIDTH (32)
  ) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (b_valid),
    .req_ready    (b_ready),
    .req_data     (b_data),
    .result_valid (b_res_valid),
    .result_ready (b_res_ready),
    .result_data  (b_res_data),
    .result_tag   (b_res_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic        rready;
    logic [3:0]  ready;
    logic        rvalid;
    logic [31:0] data;
    logic [1:0]  tag;
    logic [1:0]  ptr;
  } vec_t;

  vec_t tbl [24];

  // Continuous protocol monitor on the 64->32 instance
  logic        armed;
  logic        p_valid;
  logic [31:0] p_data;
  logic [1:0]  p_tag;

  always @(negedge clk) begin
    if (!rst_n) chk("ready_in_reset", 64'(a_ready), 64'h0);
    chk("onehot0_a", 64'($onehot0(a_ready)), 64'h1);
    chk("onehot0_b", 64'($onehot0(b_ready)), 64'h1);
    if (armed) begin
      chk("stable_valid", 64'(a_res_valid), 64'(p_valid));
      chk("stable_data", 64'(a_res_data), 64'(p_data));
      chk("stable_tag", 64'(a_res_tag), 64'(p_tag));
    end
    armed   = rst_n && a_res_valid && !a_res_ready;
    p_valid = a_res_valid;
    p_data  = a_res_data;
    p_tag   = a_res_tag;
  end

  initial begin
    clk         = 1'b0;
    rst_n       = 1'b0;
    errors      = 0;
    checks      = 0;
    armed       = 1'b0;
    a_valid     = 4'hF;
    a_res_ready = 1'b0;
    a_data      = {64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_8000_0001,
                   64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444};
    b_valid     = 4'h0;
    b_res_ready = 1'b1;
    b_data      = {16'h0000, 16'h0000, 16'h7FFF, 16'h8001};

    tbl[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 32'h8000_0001, 2'd2, 2'd3};
    tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 32'h8000_0001, 2'd2, 2'd3};
    tbl[2]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 32'h8000_0001, 2'd2, 2'd3};
    tbl[3]  = '{4'b1000, 1'b1, 4'b1000, 1'b1, 32'h89AB_CDEF, 2'd3, 2'd0};
    for (int k = 0; k < 2; k++) begin
      tbl[4+4*k] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 32'h3333_4444, 2'd0, 2'd1};
      tbl[5+4*k] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 32'hCCCC_DDDD, 2'd1, 2'd2};
      tbl[6+4*k] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 32'h8000_0001, 2'd2, 2'd3};
      tbl[7+4*k] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 32'h89AB_CDEF, 2'd3, 2'd0};
    end
    for (int k = 12; k < 17; k++)
      tbl[k] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 32'h89AB_CDEF, 2'd3, 2'd0};
    tbl[17] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 32'h3333_4444, 2'd0, 2'd1};
    tbl[18] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 32'h3333_4444, 2'd0, 2'd1};
    tbl[19] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 32'h8000_0001, 2'd2, 2'd3};
    tbl[20] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 32'hCCCC_DDDD, 2'd1, 2'd2};
    tbl[21] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 32'h89AB_CDEF, 2'd3, 2'd0};
    tbl[22] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 32'h3333_4444, 2'd0, 2'd1};
    tbl[23] = '{4'b1001, 1'b0, 4'b0000, 1'b1, 32'h3333_4444, 2'd0, 2'd1};

    @(negedge clk);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_valid", 64'(a_res_valid), 64'h0);
    chk("rst_data", 64'(a_res_data), 64'h0);
    chk("rst_tag", 64'(a_res_tag), 64'h0);
    chk("rst_ptr", 64'(dut_a.rr_ptr), 64'h0);
    rst_n   = 1'b1;
    a_valid = 4'h0;

    for (int i = 0; i < 24; i++) begin
      a_valid     = tbl[i].valid;
      a_res_ready = tbl[i].rready;
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), 64'(a_ready), 64'(tbl[i].ready));
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), 64'(a_res_valid), 64'(tbl[i].rvalid));
      chk($sformatf("v%0d_data", i), 64'(a_res_data), 64'(tbl[i].data));
      chk($sformatf("v%0d_tag", i), 64'(a_res_tag), 64'(tbl[i].tag));
      chk($sformatf("v%0d_ptr", i), 64'(dut_a.rr_ptr), 64'(tbl[i].ptr));
    end

    // Reset pulse with a held result and rr_ptr=1
    rst_n       = 1'b0;
    a_valid     = 4'b1001;
    a_res_ready = 1'b0;
    @(negedge clk);
    chk("rp_ready", 64'(a_ready), 64'h0);
    @(posedge clk); #1;
    chk("rp_valid", 64'(a_res_valid), 64'h0);
    chk("rp_data", 64'(a_res_data), 64'h0);
    chk("rp_tag", 64'(a_res_tag), 64'h0);
    chk("rp_ptr", 64'(dut_a.rr_ptr), 64'h0);
    rst_n       = 1'b1;
    a_res_ready = 1'b1;
    @(negedge clk);
    chk("rp_first_ready", 64'(a_ready), 64'h1);
    @(posedge clk); #1;
    chk("rp_first_valid", 64'(a_res_valid), 64'h1);
    chk("rp_first_tag", 64'(a_res_tag), 64'h0);
    chk("rp_first_data", 64'(a_res_data), 64'h3333_4444);
    a_valid = 4'b0000;

    // Sign extension on the 16->32 instance
    b_valid = 4'b0001;
    @(negedge clk);
    chk("ext0_ready", 64'(b_ready), 64'h1);
    @(posedge clk); #1;
    chk("ext0_valid", 64'(b_res_valid), 64'h1);
    chk("ext0_data", 64'(b_res_data), 64'hFFFF_8001);
    chk("ext0_tag", 64'(b_res_tag), 64'h0);
    b_valid = 4'b0010;
    @(negedge clk);
    chk("ext1_ready", 64'(b_ready), 64'h2);
    @(posedge clk); #1;
    chk("ext1_data", 64'(b_res_data), 64'h0000_7FFF);
    chk("ext1_tag", 64'(b_res_tag), 64'h1);
    b_valid = 4'b0000;
    @(posedge clk); #1;
    chk("ext_drain_valid", 64'(b_res_valid), 64'h0);
    chk("ext_drain_data", 64'(b_res_data), 64'h0000_7FFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
